pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_data_reg.sv | 25 ++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage register: state encoding and bundle width.
package pipe_pkg;

  localparam int unsigned IDEX_WIDTH = 193;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StFull  = 2'b01,
    StSkid  = 2'b10
  } state_e;

  function automatic logic [1:0] state_occupancy(input state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      StFull:  occ = 2'd1;
      StSkid:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and asynchronous active-high reset to RESET_VALUE.
module pipe_data_reg #(
  parameter int unsigned     WIDTH       = 193,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VALUE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register; define PIPE_STAGE_REG_SKID_EN to add a skid slot
// so in_ready is decoded from registered state only.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = IDEX_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
`ifdef PIPE_STAGE_REG_SKID_EN
  logic             w_skid_en;
  logic [WIDTH-1:0] w_skid_q;
`endif

  assign out_valid = (r_state != StEmpty);
  assign occupancy = state_occupancy(r_state);
  assign out_data  = w_main_q;

`ifdef PIPE_STAGE_REG_SKID_EN
  assign in_ready = !flush && (r_state != StSkid);
`else
  assign in_ready = !flush && (!out_valid || out_ready);
`endif

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush wins over any fire and leaves both payload slots untouched.
  always_comb begin
    w_state_next = r_state;
    w_main_en    = 1'b0;
    w_main_d     = in_data;
`ifdef PIPE_STAGE_REG_SKID_EN
    w_skid_en    = 1'b0;
`endif
    if (flush) begin
      w_state_next = StEmpty;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_main_en    = 1'b1;
            w_state_next = StFull;
          end
        end
        StFull: begin
          if (w_in_fire && w_out_fire) begin
            w_main_en = 1'b1;
          end else if (w_out_fire) begin
            w_state_next = StEmpty;
`ifdef PIPE_STAGE_REG_SKID_EN
          end else if (w_in_fire) begin
            w_skid_en    = 1'b1;
            w_state_next = StSkid;
`endif
          end
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        StSkid: begin
          if (out_ready) begin
            w_main_en    = 1'b1;
            w_main_d     = w_skid_q;
            w_state_next = StFull;
          end
        end
`endif
        default: w_state_next = StEmpty;
      endcase
    end
  end

  pipe_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_main_reg (
    .clk (clk),
    .rst (rst),
    .i_en(w_main_en),
    .i_d (w_main_d),
    .o_q (w_main_q)
  );

`ifdef PIPE_STAGE_REG_SKID_EN
  pipe_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .i_en(w_skid_en),
    .i_d (in_data),
    .o_q (w_skid_q)
  );
`endif

endmodule
